// File: rtl/accel_fastram_if.sv
`timescale 1ns/1ps
// accel_fastram_if: CPU-side bus, SRAM strobes and MapROM control/status
// for accel_fastram_ctrl.
//   slave  : controller side (samples CPU signals, drives SRAM/DTACK/status)
//   master : CPU / environment side
interface accel_fastram_if #(
    parameter int unsigned NUM_WIN = 4,
    parameter int unsigned ADDR_W  = 5
);
    logic               AS_ACCEL;
    logic               UDS;
    logic               LDS;
    logic               RW;
    logic [ADDR_W-1:0]  ADDRESS;
    logic [NUM_WIN-1:0] WIN_ENABLE;
    logic               MAPROM_ARM;
    logic               MAPROM_CLEAR;
    logic               RAM_CE_n;
    logic               RAM_OE_n;
    logic               RAM_WR_n;
    logic               RAM_UB_n;
    logic               RAM_LB_n;
    logic               DTACK_FAST_n;
    logic [NUM_WIN-1:0] WIN_HIT;
    logic               MAPROM_WRITTEN;
    logic               MAPROM_ENABLED;

    modport slave (
        input  AS_ACCEL, UDS, LDS, RW, ADDRESS, WIN_ENABLE, MAPROM_ARM, MAPROM_CLEAR,
        output RAM_CE_n, RAM_OE_n, RAM_WR_n, RAM_UB_n, RAM_LB_n, DTACK_FAST_n,
               WIN_HIT, MAPROM_WRITTEN, MAPROM_ENABLED
    );

    modport master (
        output AS_ACCEL, UDS, LDS, RW, ADDRESS, WIN_ENABLE, MAPROM_ARM, MAPROM_CLEAR,
        input  RAM_CE_n, RAM_OE_n, RAM_WR_n, RAM_UB_n, RAM_LB_n, DTACK_FAST_n,
               WIN_HIT, MAPROM_WRITTEN, MAPROM_ENABLED
    );
endinterface

// File: rtl/accel_fastram_ctrl.sv
`timescale 1ns/1ps
// accel_fastram_ctrl: single-clock SRAM controller for the accelerator's
// local RAM. Decodes NUM_WIN address windows, runs the SRAM strobe sequence
// with programmable wait states and returns a fast /DTACK for claimed cycles.
// One window may act as a write-once MapROM (fill, then lock and arm reads).
// Ports:
//   CLK_ACCEL : accelerator clock, rising edge
//   RESET     : asynchronous active-low reset
//   bus       : accel_fastram_if.slave (CPU strobes/address, window enables,
//               MapROM arm/clear in; SRAM strobes, DTACK, WIN_HIT, MapROM flags out)
module accel_fastram_ctrl #(
    parameter int unsigned               NUM_WIN      = 4,
    parameter int unsigned               ADDR_W       = 5,
    parameter logic [NUM_WIN*ADDR_W-1:0] WIN_BASE     = {5'h1F, 5'h1A, 5'h19, 5'h18},
    parameter int unsigned               WAIT_STATES  = 1,
    parameter int unsigned               MAPROM_WIN   = 3,
    parameter int unsigned               MAPROM_WORDS = 262144
) (
    input  logic           CLK_ACCEL,
    input  logic           RESET,
    accel_fastram_if.slave bus
);

    // Counter holds the full MAPROM_WORDS value so it can saturate there.
    localparam int unsigned CNT_W  = $clog2(MAPROM_WORDS + 1);
    localparam int unsigned WCNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [WCNT_W-1:0]   w_wcnt_nxt;
    logic                r_ce_n, r_oe_n, r_wr_n, r_ub_n, r_lb_n, r_dtack_n;
    logic                w_ce_n_nxt, w_oe_n_nxt, w_wr_n_nxt, w_ub_n_nxt, w_lb_n_nxt, w_dtack_n_nxt;
    logic [NUM_WIN-1:0]  r_hit;
    logic [NUM_WIN-1:0]  w_hit_nxt;

    logic [NUM_WIN-1:0]  w_hit;
    logic                w_found;
    logic                w_is_mrom;
    logic                w_claim;
    logic                w_start;
    logic                w_abort;
    logic                w_ack_entry;

    logic                r_written;
    logic                r_enabled;
    logic                r_pend;
    logic [CNT_W-1:0]    r_cnt;

    // Window decode: lowest matching enabled window wins, then MapROM gating.
    always_comb begin
        w_hit     = '0;
        w_found   = 1'b0;
        w_is_mrom = 1'b0;
        for (int unsigned i = 0; i < NUM_WIN; i++) begin
            if (!w_found && bus.WIN_ENABLE[i] &&
                (bus.ADDRESS == WIN_BASE[i*ADDR_W +: ADDR_W])) begin
                w_found   = 1'b1;
                w_hit     = NUM_WIN'(1) << i;
                w_is_mrom = (i == MAPROM_WIN);
            end
        end
        w_claim = w_found && (!w_is_mrom ||
                              ( bus.RW &&  r_enabled) ||
                              (!bus.RW && !r_written));
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_wcnt_nxt    = r_wcnt;
        w_ce_n_nxt    = r_ce_n;
        w_oe_n_nxt    = r_oe_n;
        w_wr_n_nxt    = r_wr_n;
        w_ub_n_nxt    = r_ub_n;
        w_lb_n_nxt    = r_lb_n;
        w_dtack_n_nxt = r_dtack_n;
        w_hit_nxt     = r_hit;
        w_start       = 1'b0;
        w_abort       = (r_state != S_IDLE) && bus.AS_ACCEL;

        case (r_state)
            S_IDLE: begin
                w_ce_n_nxt    = 1'b1;
                w_oe_n_nxt    = 1'b1;
                w_wr_n_nxt    = 1'b1;
                w_ub_n_nxt    = 1'b1;
                w_lb_n_nxt    = 1'b1;
                w_dtack_n_nxt = 1'b1;
                w_hit_nxt     = '0;
                if (!bus.AS_ACCEL && w_claim) begin
                    w_state_nxt = S_STROBE;
                    w_ce_n_nxt  = 1'b0;
                    w_hit_nxt   = w_hit;
                    w_start     = 1'b1;
                end
            end
            // Waits here until at least one data strobe is low.
            S_STROBE: begin
                if (!bus.UDS || !bus.LDS) begin
                    w_ub_n_nxt = bus.UDS;
                    w_lb_n_nxt = bus.LDS;
                    w_oe_n_nxt = !bus.RW;
                    w_wr_n_nxt = bus.RW;
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = S_ACK;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_wcnt_nxt  = WCNT_W'(WAIT_STATES);
                    end
                end
            end
            // WAIT lasts exactly WAIT_STATES clocks.
            S_WAIT: begin
                if (r_wcnt <= WCNT_W'(1)) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_wcnt_nxt = r_wcnt - WCNT_W'(1);
                end
            end
            S_ACK: begin
                w_dtack_n_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // /AS released: drop everything on the next edge.
        if (w_abort) begin
            w_state_nxt   = S_IDLE;
            w_ce_n_nxt    = 1'b1;
            w_oe_n_nxt    = 1'b1;
            w_wr_n_nxt    = 1'b1;
            w_ub_n_nxt    = 1'b1;
            w_lb_n_nxt    = 1'b1;
            w_dtack_n_nxt = 1'b1;
            w_hit_nxt     = '0;
        end

        w_ack_entry = (w_state_nxt == S_ACK) && (r_state != S_ACK);
    end

    // State and output registers.
    always_ff @(posedge CLK_ACCEL or negedge RESET) begin
        if (!RESET) begin
            r_state   <= S_IDLE;
            r_wcnt    <= '0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_ub_n    <= 1'b1;
            r_lb_n    <= 1'b1;
            r_dtack_n <= 1'b1;
            r_hit     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_ce_n    <= w_ce_n_nxt;
            r_oe_n    <= w_oe_n_nxt;
            r_wr_n    <= w_wr_n_nxt;
            r_ub_n    <= w_ub_n_nxt;
            r_lb_n    <= w_lb_n_nxt;
            r_dtack_n <= w_dtack_n_nxt;
            r_hit     <= w_hit_nxt;
        end
    end

    // MapROM fill counter and flags. r_pend marks a MapROM write in flight;
    // CLEAR drops it so an in-flight write is not counted.
    always_ff @(posedge CLK_ACCEL or negedge RESET) begin
        if (!RESET) begin
            r_written <= 1'b0;
            r_enabled <= 1'b0;
            r_pend    <= 1'b0;
            r_cnt     <= '0;
        end else if (bus.MAPROM_CLEAR) begin
            r_written <= 1'b0;
            r_enabled <= 1'b0;
            r_pend    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (bus.MAPROM_ARM && r_written) begin
                r_enabled <= 1'b1;
            end
            if (w_start) begin
                r_pend <= w_is_mrom && !bus.RW;
            end else if (w_ack_entry) begin
                r_pend <= 1'b0;
            end
            if (w_ack_entry && r_pend && !r_written) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(MAPROM_WORDS - 1)) begin
                    r_written <= 1'b1;
                end
            end
        end
    end

    assign bus.RAM_CE_n       = r_ce_n;
    assign bus.RAM_OE_n       = r_oe_n;
    assign bus.RAM_WR_n       = r_wr_n;
    assign bus.RAM_UB_n       = r_ub_n;
    assign bus.RAM_LB_n       = r_lb_n;
    assign bus.DTACK_FAST_n   = r_dtack_n;
    assign bus.WIN_HIT        = r_hit;
    assign bus.MAPROM_WRITTEN = r_written;
    assign bus.MAPROM_ENABLED = r_enabled;

endmodule
